// File: rtl/car_led_decoder.sv
// car_led_decoder: recovers the driver command from the two 3-bit tail-light
// patterns seen on the rear-light bus, and flags illegal or broken sequences.
//
// Optional feature macro: CAR_LED_DEC_HOLD_EN
//   When defined, an unmatched decision keeps the last valid mode for up to HOLD cycles.
//   When undefined, an unmatched decision drives mode=7 on the same edge.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-low reset
//   led_left       in   [2:0] left lamp pattern (bit0=a, bit1=b, bit2=c)
//   led_right      in   [2:0] right lamp pattern
//   mode           out  [2:0] decoded command (0..6, 7 = unknown)
//   valid          out  mode != 7
//   left_det       out  mode in {1,4}
//   right_det      out  mode in {2,5}
//   brake_det      out  mode in {3,4,5}
//   emergency_det  out  mode == 6
//   error          out  one-cycle pulse on an illegal sample or both sides sweeping
//   error_cnt      out  [7:0] saturating count of error pulses
module car_led_decoder #(
    parameter int unsigned LOCK   = 4,
    parameter int unsigned STEADY = 2,
    parameter int unsigned HOLD   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] led_left,
    input  logic [2:0] led_right,
    output logic [2:0] mode,
    output logic       valid,
    output logic       left_det,
    output logic       right_det,
    output logic       brake_det,
    output logic       emergency_det,
    output logic       error,
    output logic [7:0] error_cnt
);

`ifdef CAR_LED_DEC_HOLD_EN
    localparam int unsigned HOLD_MAX = HOLD;
`else
    localparam int unsigned HOLD_MAX = 0;
`endif

    localparam int unsigned LW = $clog2(LOCK + 1);
    localparam int unsigned SW = $clog2(STEADY + 1);
    localparam int unsigned HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    localparam logic [LW-1:0] LOCK_V   = LW'(LOCK);
    localparam logic [SW-1:0] STEADY_V = SW'(STEADY);
    localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_MAX);

    localparam logic [2:0] P_OFF = 3'b000;
    localparam logic [2:0] P_ONE = 3'b001;
    localparam logic [2:0] P_TWO = 3'b011;
    localparam logic [2:0] P_ALL = 3'b111;

    localparam logic [2:0] M_STRAIGHT = 3'd0;
    localparam logic [2:0] M_LEFT     = 3'd1;
    localparam logic [2:0] M_RIGHT    = 3'd2;
    localparam logic [2:0] M_BRAKE    = 3'd3;
    localparam logic [2:0] M_LBRAKE   = 3'd4;
    localparam logic [2:0] M_RBRAKE   = 3'd5;
    localparam logic [2:0] M_EMERG    = 3'd6;
    localparam logic [2:0] M_UNKNOWN  = 3'd7;

    function automatic logic is_legal(input logic [2:0] p);
        return (p == P_OFF) || (p == P_ONE) || (p == P_TWO) || (p == P_ALL);
    endfunction

    // OFF or ALL: the only patterns that can be held steady or toggled
    function automatic logic is_end(input logic [2:0] p);
        return (p == P_OFF) || (p == P_ALL);
    endfunction

    function automatic logic is_succ(input logic [2:0] prev, input logic [2:0] cur);
        return (prev == P_OFF && cur == P_ONE) || (prev == P_ONE && cur == P_TWO) ||
               (prev == P_TWO && cur == P_ALL) || (prev == P_ALL && cur == P_OFF);
    endfunction

    function automatic logic [LW-1:0] sweep_next(input logic [2:0] prev, input logic [2:0] cur,
                                                 input logic [LW-1:0] cnt);
        if (!is_succ(prev, cur)) return '0;
        return (cnt >= LOCK_V) ? LOCK_V : cnt + LW'(1);
    endfunction

    function automatic logic [SW-1:0] steady_next(input logic [2:0] prev, input logic [2:0] cur,
                                                  input logic [SW-1:0] cnt);
        if (!is_end(cur)) return '0;
        if (cur != prev) return SW'(1);
        return (cnt >= STEADY_V) ? STEADY_V : cnt + SW'(1);
    endfunction

    // Tracker state
    logic [2:0]    prev_l_q, prev_r_q;
    logic [LW-1:0] sw_l_q, sw_r_q, sw_l_d, sw_r_d, em_q, em_d;
    logic [SW-1:0] st_l_q, st_r_q, st_l_d, st_r_d;
    logic          error_q, error_d;
    logic [7:0]    error_cnt_q, error_cnt_d;

    // Output state
    logic [2:0]    mode_q, mode_d, dec;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    det_q, det_d;  // {emergency, brake, right, left}

    always_comb begin
        sw_l_d = sweep_next(prev_l_q, led_left, sw_l_q);
        sw_r_d = sweep_next(prev_r_q, led_right, sw_r_q);
        st_l_d = steady_next(prev_l_q, led_left, st_l_q);
        st_r_d = steady_next(prev_r_q, led_right, st_r_q);

        em_d = '0;
        if (led_left == led_right && is_end(led_left) &&
            led_left != prev_l_q && led_right != prev_r_q) begin
            em_d = (em_q >= LOCK_V) ? LOCK_V : em_q + LW'(1);
        end

        error_d = !is_legal(led_left) || !is_legal(led_right) ||
                  (sw_l_d >= LOCK_V && sw_r_d >= LOCK_V);
        error_cnt_d = (error_d && error_cnt_q != 8'hFF) ? error_cnt_q + 8'd1 : error_cnt_q;
    end

    // Decision uses the registered trackers, giving one cycle of latency to mode
    always_comb begin
        logic l_sweep, r_sweep, l_off, l_all, r_off, r_all;
        l_sweep = sw_l_q >= LOCK_V;
        r_sweep = sw_r_q >= LOCK_V;
        l_off   = st_l_q >= STEADY_V && prev_l_q == P_OFF;
        l_all   = st_l_q >= STEADY_V && prev_l_q == P_ALL;
        r_off   = st_r_q >= STEADY_V && prev_r_q == P_OFF;
        r_all   = st_r_q >= STEADY_V && prev_r_q == P_ALL;

        dec = M_UNKNOWN;
        if (em_q >= LOCK_V)          dec = M_EMERG;
        else if (l_sweep && r_off)   dec = M_LEFT;
        else if (l_sweep && r_all)   dec = M_LBRAKE;
        else if (r_sweep && l_off)   dec = M_RIGHT;
        else if (r_sweep && l_all)   dec = M_RBRAKE;
        else if (l_off && r_off)     dec = M_STRAIGHT;
        else if (l_all && r_all)     dec = M_BRAKE;

        mode_d = dec;
        hold_d = '0;
        if (error_q) begin
            mode_d = M_UNKNOWN;
        end else if (HOLD_MAX != 0 && dec == M_UNKNOWN && mode_q != M_UNKNOWN &&
                     hold_q != HOLD_V) begin
            mode_d = mode_q;
            hold_d = hold_q + HW'(1);
        end

        det_d[0] = (mode_d == M_LEFT) || (mode_d == M_LBRAKE);
        det_d[1] = (mode_d == M_RIGHT) || (mode_d == M_RBRAKE);
        det_d[2] = (mode_d == M_BRAKE) || (mode_d == M_LBRAKE) || (mode_d == M_RBRAKE);
        det_d[3] = (mode_d == M_EMERG);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_l_q    <= P_OFF;
            prev_r_q    <= P_OFF;
            sw_l_q      <= '0;
            sw_r_q      <= '0;
            st_l_q      <= '0;
            st_r_q      <= '0;
            em_q        <= '0;
            error_q     <= 1'b0;
            error_cnt_q <= '0;
            mode_q      <= M_UNKNOWN;
            hold_q      <= '0;
            det_q       <= '0;
        end else begin
            prev_l_q    <= led_left;
            prev_r_q    <= led_right;
            sw_l_q      <= sw_l_d;
            sw_r_q      <= sw_r_d;
            st_l_q      <= st_l_d;
            st_r_q      <= st_r_d;
            em_q        <= em_d;
            error_q     <= error_d;
            error_cnt_q <= error_cnt_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            det_q       <= det_d;
        end
    end

    assign mode          = mode_q;
    assign valid         = (mode_q != M_UNKNOWN);
    assign left_det      = det_q[0];
    assign right_det     = det_q[1];
    assign brake_det     = det_q[2];
    assign emergency_det = det_q[3];
    assign error         = error_q;
    assign error_cnt     = error_cnt_q;

endmodule

// File: tb/tb_car_led_decoder.sv
// Testbench for car_led_decoder: drives directed and random lamp sequences, predicts
// every cycle's outputs with a reference model into a queue, and a monitor compares.
module tb_car_led_decoder;
    localparam int LOCK   = 4;
    localparam int STEADY = 2;
    localparam int HOLD   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] led_left = 3'b000;
    logic [2:0] led_right = 3'b000;
    logic [2:0] mode;
    logic       valid, left_det, right_det, brake_det, emergency_det, error;
    logic [7:0] error_cnt;

    car_led_decoder #(.LOCK(LOCK), .STEADY(STEADY), .HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .led_left(led_left), .led_right(led_right),
        .mode(mode), .valid(valid), .left_det(left_det), .right_det(right_det),
        .brake_det(brake_det), .emergency_det(emergency_det), .error(error),
        .error_cnt(error_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int err;
        int ecnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [2:0] sw_tbl [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

    // Reference model state, kept as plain integers
    int m_lp, m_rp, m_lsw, m_rsw, m_lst, m_rst, m_em, m_ecnt, m_mode, m_hold, m_err;

    function automatic int cls(input int p);
        case (p)
            0: return 0;
            1: return 1;
            3: return 2;
            7: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int sweep_upd(input int prev, input int cur, input int cnt);
        int pc = cls(prev);
        int cc = cls(cur);
        if (pc >= 0 && cc >= 0 && cc == (pc + 1) % 4) return min2(cnt + 1, LOCK);
        return 0;
    endfunction

    function automatic int steady_upd(input int prev, input int cur, input int cnt);
        if (cur != 0 && cur != 7) return 0;
        if (cur != prev) return 1;
        return min2(cnt + 1, STEADY);
    endfunction

    task automatic model_step(input bit rn, input int l, input int r);
        int dec;
        bit ls, rs, loff, lall, roff, rall;
        if (!rn) begin
            m_lp = 0; m_rp = 0; m_lsw = 0; m_rsw = 0; m_lst = 0; m_rst = 0;
            m_em = 0; m_ecnt = 0; m_mode = 7; m_hold = 0; m_err = 0;
            return;
        end
        // Output decision from tracker values before this edge
        ls   = m_lsw >= LOCK;
        rs   = m_rsw >= LOCK;
        loff = m_lst >= STEADY && m_lp == 0;
        lall = m_lst >= STEADY && m_lp == 7;
        roff = m_rst >= STEADY && m_rp == 0;
        rall = m_rst >= STEADY && m_rp == 7;
        if (m_em >= LOCK)      dec = 6;
        else if (ls && roff)   dec = 1;
        else if (ls && rall)   dec = 4;
        else if (rs && loff)   dec = 2;
        else if (rs && lall)   dec = 5;
        else if (loff && roff) dec = 0;
        else if (lall && rall) dec = 3;
        else                   dec = 7;
`ifdef CAR_LED_DEC_HOLD_EN
        if (m_err != 0) begin
            m_mode = 7; m_hold = 0;
        end else if (dec != 7) begin
            m_mode = dec; m_hold = 0;
        end else if (m_mode != 7 && m_hold < HOLD) begin
            m_hold = m_hold + 1;
        end else begin
            m_mode = 7; m_hold = 0;
        end
`else
        m_mode = dec;
`endif
        // Tracker updates from this sample
        if (l == r && (l == 0 || l == 7) && l != m_lp && r != m_rp) m_em = min2(m_em + 1, LOCK);
        else m_em = 0;
        m_lsw = sweep_upd(m_lp, l, m_lsw);
        m_rsw = sweep_upd(m_rp, r, m_rsw);
        m_lst = steady_upd(m_lp, l, m_lst);
        m_rst = steady_upd(m_rp, r, m_rst);
        m_lp = l;
        m_rp = r;
        m_err = (cls(l) < 0 || cls(r) < 0 || (m_lsw >= LOCK && m_rsw >= LOCK)) ? 1 : 0;
        if (m_err != 0) m_ecnt = min2(m_ecnt + 1, 255);
    endtask

    task automatic step(input bit rn, input logic [2:0] l, input logic [2:0] r);
        exp_t e;
        @(negedge clk);
        reset = rn;
        led_left = l;
        led_right = r;
        model_step(rn, int'(l), int'(r));
        e.mode = m_mode;
        e.err  = m_err;
        e.ecnt = m_ecnt;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge once stimulus has started
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mode", 8'(mode), 8'(e.mode));
                chk("valid", 8'(valid), 8'(e.mode != 7));
                chk("left_det", 8'(left_det), 8'(e.mode == 1 || e.mode == 4));
                chk("right_det", 8'(right_det), 8'(e.mode == 2 || e.mode == 5));
                chk("brake_det", 8'(brake_det), 8'(e.mode >= 3 && e.mode <= 5));
                chk("emergency_det", 8'(emergency_det), 8'(e.mode == 6));
                chk("error", 8'(error), 8'(e.err));
                chk("error_cnt", error_cnt, 8'(e.ecnt));
            end
        end
    end

    initial begin
        int pos;
        int kind;
        int len;
        logic [2:0] hl, a, b;
        bit rn;

        // Reset with random lamps, then both OFF -> straight
        repeat (2) step(1'b0, 3'($urandom), 3'($urandom));
        repeat (4) step(1'b1, 3'b000, 3'b000);

        // Left sweep with right OFF
        for (int i = 0; i < 14; i++) step(1'b1, sw_tbl[i % 4], 3'b000);

        // Lockstep emergency toggles starting ALL, then stop
        step(1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 8; i++) step(1'b1, (i % 2) ? 3'b000 : 3'b111, (i % 2) ? 3'b000 : 3'b111);
        repeat (4) step(1'b1, 3'b111, 3'b111);

        // Right sweep with left ALL held, then right ALL steady
        step(1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 12; i++) step(1'b1, 3'b111, sw_tbl[i % 4]);
        repeat (4) step(1'b1, 3'b111, 3'b111);

        // Left sweep broken by one illegal sample, then resumed from OFF
        step(1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 10; i++) step(1'b1, sw_tbl[i % 4], 3'b000);
        step(1'b1, 3'b101, 3'b000);
        for (int i = 0; i < 8; i++) step(1'b1, sw_tbl[i % 4], 3'b000);

        // Left sweep with a 2-cycle gap
        for (int i = 0; i < 3; i++) step(1'b1, sw_tbl[(i + 8) % 4], 3'b000);
        repeat (2) step(1'b1, 3'b011, 3'b000);
        for (int i = 0; i < 6; i++) step(1'b1, sw_tbl[(i + 3) % 4], 3'b000);

        // Reset while emergency is locked
        for (int i = 0; i < 6; i++) step(1'b1, (i % 2) ? 3'b111 : 3'b000, (i % 2) ? 3'b111 : 3'b000);
        step(1'b0, 3'($urandom), 3'($urandom));
        repeat (2) step(1'b1, 3'b111, 3'b111);

        // Error counter saturation
        for (int i = 0; i < 300; i++) step(1'b1, 3'b101, 3'($urandom));

        // Random segments of sweeps, toggles, steady and junk
        pos = 0;
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(2, 10);
            hl   = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
            for (int k = 0; k < len; k++) begin
                rn  = ($urandom_range(0, 79) != 0);
                pos = (pos + 1) % 4;
                case (kind)
                    0: begin a = sw_tbl[pos]; b = hl; end
                    1: begin a = hl; b = sw_tbl[pos]; end
                    2: begin a = (pos % 2 != 0) ? 3'b111 : 3'b000; b = a; end
                    3: begin a = hl; b = ($urandom_range(0, 3) != 0) ? hl : ~hl; end
                    4: begin a = 3'($urandom); b = 3'($urandom); end
                    default: begin a = sw_tbl[pos]; b = sw_tbl[pos]; end
                endcase
                step(rn, a, b);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
